// File: rtl/rng_collector_pkg.sv
// Shared types and width helpers for the random-bit word collector.
package rng_collector_pkg;

  typedef enum logic {FULL_STALL, FULL_DROP} full_policy_t;

  // Width of the partial-word bit counter; never narrower than one bit.
  function automatic int cnt_width(input int word_w);
    return (word_w <= 2) ? 1 : $clog2(word_w);
  endfunction

  function automatic full_policy_t policy_of(input int drop_on_full);
    return (drop_on_full != 0) ? FULL_DROP : FULL_STALL;
  endfunction

endpackage

// File: rtl/rng_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module rng_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/nbit_word_collector.sv
// Packs a serial random-bit stream into WORD_W-bit words behind a
// ready/valid source port, with resync clear and dropped-word counting.
module nbit_word_collector
  import rng_collector_pkg::*;
#(
  parameter int WORD_W       = 8,
  parameter int LSB_FIRST    = 0,
  parameter int DROP_ON_FULL = 0,
  parameter int DROP_CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          snk_data,
  input  logic                          snk_valid,
  output logic                          snk_ready,
  input  logic                          sync_clear,
  output logic [WORD_W-1:0]             src_data,
  output logic                          src_valid,
  input  logic                          src_ready,
  output logic [cnt_width(WORD_W)-1:0]  bit_count,
  output logic [DROP_CNT_W-1:0]         drop_count
);

  localparam int           CW     = cnt_width(WORD_W);
  localparam full_policy_t POLICY = policy_of(DROP_ON_FULL);

  logic [WORD_W-1:0] sr;
  logic [WORD_W-1:0] sr_next;
  logic              last_bit;
  logic              accept;
  logic              complete;
  logic              reg_free;
  logic              load;
  logic              drop;

  assign last_bit = (bit_count == CW'(WORD_W - 1));
  assign reg_free = ~src_valid | src_ready;

  // Stall mode only blocks the bit that would complete a word with nowhere to go.
  always_comb begin
    snk_ready = 1'b1;
    if (POLICY == FULL_STALL) begin
      snk_ready = ~(last_bit & src_valid & ~src_ready);
    end
  end

  assign accept   = snk_valid & snk_ready & ~sync_clear;
  assign complete = accept & last_bit;
  assign load     = complete & reg_free;
  assign drop     = complete & ~reg_free & (POLICY == FULL_DROP);

  generate
    if (LSB_FIRST != 0) begin : g_lsb_first
      assign sr_next = {snk_data, sr[WORD_W-1:1]};
    end else begin : g_msb_first
      assign sr_next = {sr[WORD_W-2:0], snk_data};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= '0;
      bit_count <= '0;
      src_data  <= '0;
      src_valid <= 1'b0;
    end else begin
      if (sync_clear) begin
        sr        <= '0;
        bit_count <= '0;
      end else if (accept) begin
        sr        <= sr_next;
        bit_count <= last_bit ? '0 : bit_count + CW'(1);
      end

      // A load in the same cycle as a transfer keeps src_valid high: no bubble.
      if (load) begin
        src_data  <= sr_next;
        src_valid <= 1'b1;
      end else if (src_ready) begin
        src_valid <= 1'b0;
      end
    end
  end

  rng_sat_counter #(
    .W (DROP_CNT_W)
  ) u_drop_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (drop),
    .count (drop_count)
  );

endmodule

// File: doc/nbit_word_collector.md
Name: nbit_word_collector

Overview:
- Assembles a serial stream of single random bits into WORD_W-bit words and presents them on a ready/valid source interface.
- Generalised successor of the fixed 2-bit collector in the random_number_generator IP: word width, bit order and full-output policy are parameters.
- Adds backpressure, a resync clear and an overflow counter.
- Sits between the entropy bit source (with or without the whitener) and downstream word consumers: FIFO, CSR readout, DMA.

Parameters:
- WORD_W, 8, output word width in bits; legal range 2..64.
- LSB_FIRST, 0, 0 = first received bit lands in src_data[WORD_W-1]; 1 = first received bit lands in src_data[0].
- DROP_ON_FULL, 0, 0 = stall the sink when a completed word cannot be stored; 1 = always accept bits and discard words that cannot be stored.
- DROP_CNT_W, 16, width of the saturating dropped-word counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- snk_data  in  1  serial random bit
- snk_valid  in  1  snk_data qualifier
- snk_ready  out  1  collector can accept a bit this cycle
- sync_clear  in  1  discard the partially assembled word
- src_data  out  WORD_W  assembled word
- src_valid  out  1  src_data holds an unconsumed word
- src_ready  in  1  downstream accepts the word
- bit_count  out  $clog2(WORD_W)  bits in the partial word
- drop_count  out  DROP_CNT_W  saturating count of discarded words

Behaviour:
- Clocking: single clock. Reset is synchronous and active-high; all state updates occur on rising clk.
- Reset values: src_data=0, src_valid=0, bit_count=0, drop_count=0, internal shift register sr=0. snk_ready follows its combinational equation.
- Bit acceptance: a bit is accepted when snk_valid & snk_ready & ~sync_clear.
  - LSB_FIRST=0: sr <= {sr[WORD_W-2:0], snk_data}.
  - LSB_FIRST=1: sr <= {snk_data, sr[WORD_W-1:1]}.
  - bit_count increments on each accepted bit.
- Word completion: an accepted bit with bit_count==WORD_W-1.
  - The assembled value (sr shifted with the new bit) is the word; bit_count wraps to 0.
  - The word goes to the output register when the register is free: ~src_valid, or src_valid & src_ready in the same cycle.
  - Then src_data <= word and src_valid <= 1 on the next edge. Latency from last bit to src_valid is 1 cycle.
- Output handshake: a transfer occurs when src_valid & src_ready. If no new word is loaded in that cycle, src_valid <= 0 next cycle. src_data is held stable while src_valid & ~src_ready.
- DROP_ON_FULL=0:
  - snk_ready = ~(bit_count==WORD_W-1 & src_valid & ~src_ready).
  - The snk_ready to src_ready combinational path is intentional.
  - No word is ever lost; drop_count stays 0.
- DROP_ON_FULL=1:
  - snk_ready = 1 always.
  - A completed word that finds the register occupied and not draining is discarded. The output register is unchanged, bit_count wraps to 0, and drop_count increments, saturating at all-ones.
- sync_clear:
  - Clears bit_count and sr on the next edge.
  - Has priority over a coincident bit; that bit is dropped and is not counted.
  - Does not affect src_data, src_valid or drop_count.
- Simultaneous events: consume and completion in the same cycle loads the new word with src_valid staying 1, giving back-to-back words with no bubble.
- Reset mid-word: the partial word and any held output are lost.
- Throughput: one bit per cycle sustained when src_ready is held high.

Decomposition:
- Package rng_collector_pkg:
  - Function clog2-safe width helper for bit_count (minimum width 1).
  - Typedef enum full_policy_t {FULL_STALL, FULL_DROP}, mapped from DROP_ON_FULL.
- One sub-module, rng_sat_counter: a parametrised-width saturating incrementer with synchronous clear, used for drop_count.
- Shift register, bit counter and output register stay in the top module.

Test Plan:
- Basic MSB-first: WORD_W=8, LSB_FIRST=0, src_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> src_data=8'hB2 with src_valid=1 for exactly 1 cycle, one cycle after the 8th bit; bit_count returns to 0.
- LSB-first: same bit stream with LSB_FIRST=1 -> src_data=8'h4D.
- Stall mode: DROP_ON_FULL=0, src_ready=0, 16 bits of 1 supplied continuously -> first word 8'hFF is held; snk_ready=0 while bit_count=7; raising src_ready -> second 8'hFF appears the next cycle; drop_count=0.
- Drop mode: DROP_ON_FULL=1, src_ready=0, 24 bits supplied -> src_data keeps the first word; drop_count=2; snk_ready stays 1 throughout.
- Resync: 5 bits, sync_clear pulse coincident with the 6th bit, then 8 bits of pattern 8'hA5 -> output is 8'hA5 only; the 6th bit is ignored.
- Reset mid-operation: src_valid=1 held and 3 partial bits, assert reset for 1 cycle -> src_valid=0, bit_count=0, drop_count=0; the next 8 bits produce a clean word.
